// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and default width.
package serial_adder_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_adder_if.sv
// Start/operand/result bundle of the serial adder; master requests, slave computes.
interface serial_adder_if
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (output start, a, b, input busy, done, sum, cout);
  modport slave  (input start, a, b, output busy, done, sum, cout);
endinterface

// File: rtl/full_adder.sv
// Full adder from two half-adder cells; the two partial carries can never both be set.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  logic s1, c1, c2;

  half_adder u_ha0 (.a(a),  .b(b),  .s(s1), .c(c1));
  half_adder u_ha1 (.a(s1), .b(ci), .s(s),  .c(c2));

  assign co = c1 | c2;
endmodule

// File: rtl/half_adder.sv
// Half-adder cell.
module half_adder (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);
  assign s = a ^ b;
  assign c = a & b;
endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: operands shift out LSB-first through one full adder with a
// registered carry; {cout,sum} = a + b is presented with a one-cycle done pulse.
//
// state | meaning
// IDLE  | waiting for start; sum/cout hold the last result
// RUN   | one operand bit pair added per clock
// DONE  | done pulse cycle, returns to IDLE unconditionally
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic           clk,
  input  logic           reset,
  serial_adder_if.slave  bus
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] sa, sb, sum_q;
  logic [CW-1:0]    cnt;
  logic             carry, done_q, cout_q;
  logic             fa_s, fa_c;

  full_adder u_fa (
    .a  (sa[0]),
    .b  (sb[0]),
    .ci (carry),
    .s  (fa_s),
    .co (fa_c)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      done_q <= 1'b0;
      sum_q  <= '0;
      cout_q <= 1'b0;
      carry  <= 1'b0;
      cnt    <= '0;
      sa     <= '0;
      sb     <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            sa     <= bus.a;
            sb     <= bus.b;
            carry  <= 1'b0;
            cnt    <= '0;
            sum_q  <= '0;
            cout_q <= 1'b0;
            state  <= RUN;
          end
        end
        RUN: begin
          sum_q <= {fa_s, sum_q[WIDTH-1:1]};
          sa    <= sa >> 1;
          sb    <= sb >> 1;
          carry <= fa_c;
          cnt   <= cnt + 1'b1;
          if (cnt == LAST) begin
            state  <= DONE;
            done_q <= 1'b1;
            cout_q <= fa_c;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy = (state == RUN);
  assign bus.done = done_q;
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
endmodule
